// File: rtl/truth_table_sweeper.sv
// Sweeps every input combination of a small combinational DUT, captures its output
// into a truth table and scores each row against an expected table.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_y,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 sample_valid,
  output logic [N_IN-1:0]      sample_idx,
  output logic                 sample_err,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        err_count,
  output logic                 done,
  output logic                 pass
);

  localparam int              DEPTH    = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_ROW = '1;
  localparam logic [N_IN:0]   ERR_MAX  = (N_IN+1)'(DEPTH);
  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DEPTH-1:0]  table_q, table_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   sidx_q, sidx_d;
  logic              sval_q, sval_d;
  logic              serr_q, serr_d;
  logic              mismatch;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    stim_d   = stim_q;
    cnt_d    = cnt_q;
    table_d  = table_q;
    err_d    = err_q;
    sidx_d   = sidx_q;
    sval_d   = 1'b0;
    serr_d   = 1'b0;
    mismatch = dut_y != expected[stim_q];

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          stim_d  = '0;
          cnt_d   = '0;
          table_d = '0;
          err_d   = '0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == SETTLE_C) begin
          table_d[stim_q] = dut_y;
          sidx_d          = stim_q;
          sval_d          = 1'b1;
          serr_d          = mismatch;
          if (mismatch && err_q != ERR_MAX) err_d = err_q + 1'b1;
          cnt_d = '0;
          // The last row ends the sweep; stim returns to 0 instead of wrapping.
          if (stim_q == LAST_ROW) begin
            state_d = S_DONE;
            stim_d  = '0;
          end else begin
            stim_d = stim_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      err_q   <= '0;
      sidx_q  <= '0;
      sval_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      err_q   <= err_d;
      sidx_q  <= sidx_d;
      sval_q  <= sval_d;
      serr_q  <= serr_d;
    end
  end

  assign stim         = stim_q;
  assign busy         = state_q == S_DRIVE;
  assign done         = state_q == S_DONE;
  assign pass         = done && (err_q == '0);
  assign sample_valid = sval_q;
  assign sample_idx   = sidx_q;
  assign sample_err   = serr_q;
  assign table_out    = table_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a 3-input/settle-1 instance and a 4-input/settle-0
// instance, driven with table vectors, corner sequences and random truth tables.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start3, start4;
  logic [15:0] dtab_w, etab_w;

  logic [2:0]  stim3, sidx3;
  logic        busy3, sv3, se3, done3, pass3, y3;
  logic [7:0]  tbl3;
  logic [3:0]  err3;

  logic [3:0]  stim4, sidx4;
  logic        busy4, sv4, se4, done4, pass4, y4;
  logic [15:0] tbl4;
  logic [4:0]  err4;

  // Behavioural stand-ins for the combinational DUT: a lookup into dtab_w.
  assign y3 = dtab_w[stim3];
  assign y4 = dtab_w[stim4];

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .expected(etab_w[7:0]), .dut_y(y3),
    .stim(stim3), .busy(busy3), .sample_valid(sv3), .sample_idx(sidx3), .sample_err(se3),
    .table_out(tbl3), .err_count(err3), .done(done3), .pass(pass3)
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE(0)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .expected(etab_w), .dut_y(y4),
    .stim(stim4), .busy(busy4), .sample_valid(sv4), .sample_idx(sidx4), .sample_err(se4),
    .table_out(tbl4), .err_count(err4), .done(done4), .pass(pass4)
  );

  int sel;
  logic [31:0] m_stim, m_sidx, m_tbl, m_err;
  logic        m_busy, m_sv, m_se, m_done, m_pass;

  always_comb begin
    m_stim = 32'(stim3); m_sidx = 32'(sidx3); m_tbl = 32'(tbl3); m_err = 32'(err3);
    m_busy = busy3; m_sv = sv3; m_se = se3; m_done = done3; m_pass = pass3;
    if (sel != 0) begin
      m_stim = 32'(stim4); m_sidx = 32'(sidx4); m_tbl = 32'(tbl4); m_err = 32'(err4);
      m_busy = busy4; m_sv = sv4; m_se = se4; m_done = done4; m_pass = pass4;
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (dut%0d, t=%0t): got %0h expected %0h", name, sel ? 4 : 3, $time, act, exp);
  endtask

  function automatic int popc(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit v);
    if (sel == 0) start3 = v;
    else          start4 = v;
  endtask

  task automatic zero_check(input string tag);
    check({tag, "_stim"}, m_stim, 0);
    check({tag, "_busy"}, 32'(m_busy), 0);
    check({tag, "_valid"}, 32'(m_sv), 0);
    check({tag, "_idx"}, m_sidx, 0);
    check({tag, "_serr"}, 32'(m_se), 0);
    check({tag, "_table"}, m_tbl, 0);
    check({tag, "_errcnt"}, m_err, 0);
    check({tag, "_done"}, 32'(m_done), 0);
    check({tag, "_pass"}, 32'(m_pass), 0);
  endtask

  // Model: after edge E0+k, row k/(S+1) is on stim; rows sampled so far = k/(S+1);
  // a capture is visible whenever k is a nonzero multiple of S+1; done at 2^N*(S+1).
  task automatic sweep(input int pulse_k, input int abort_k,
                       output logic [31:0] tbl, output int errs, output logic ps);
    int n, s, depth, total;
    logic [31:0] full, dt, et;
    n = (sel != 0) ? 4 : 3;
    s = (sel != 0) ? 0 : 1;
    depth = 1 << n;
    total = depth * (s + 1);
    full  = (32'd1 << depth) - 1;
    dt    = 32'(dtab_w) & full;
    et    = 32'(etab_w) & full;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    for (int k = 0; k <= total; k++) begin
      int rows;
      logic [31:0] msk;
      bit valid;
      rows  = k / (s + 1);
      msk   = (32'd1 << rows) - 1;
      valid = (k > 0) && (k % (s + 1) == 0);
      check("busy", 32'(m_busy), 32'(k < total));
      check("done", 32'(m_done), 32'(k == total));
      check("stim", m_stim, (k < total) ? 32'(k / (s + 1)) : 32'd0);
      check("sample_valid", 32'(m_sv), 32'(valid));
      if (valid) begin
        check("sample_idx", m_sidx, 32'(rows - 1));
        check("sample_err", 32'(m_se), 32'(dt[rows-1] != et[rows-1]));
      end
      check("table_out", m_tbl, dt & msk);
      check("err_count", m_err, 32'(popc((dt ^ et) & msk)));
      check("pass", 32'(m_pass), 32'((k == total) && (dt == et)));
      if (k == abort_k) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        zero_check("abort");
        tbl = m_tbl; errs = int'(m_err); ps = m_pass;
        return;
      end
      set_start(k + 1 == pulse_k);
      if (k < total) tick();
    end
    set_start(1'b0);
    tick();
    check("hold_done", 32'(m_done), 1);
    check("hold_valid", 32'(m_sv), 0);
    check("hold_stim", m_stim, 0);
    check("hold_table", m_tbl, dt);
    check("hold_err", m_err, 32'(popc(dt ^ et)));
    tbl = m_tbl; errs = int'(m_err); ps = m_pass;
  endtask

  typedef struct {
    int          sel;
    logic [15:0] dt;
    logic [15:0] et;
    logic [15:0] tbl;
    int          errs;
    bit          ps;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    logic [31:0] tbl;
    int          errs;
    logic        ps;

    vecs[0] = '{0, 16'h00E8, 16'h00E8, 16'h00E8, 0, 1'b1};  // majority, matching
    vecs[1] = '{0, 16'h00E8, 16'h00E9, 16'h00E8, 1, 1'b0};  // one wrong row (row 0)
    vecs[2] = '{0, 16'h00E8, 16'h0017, 16'h00E8, 8, 1'b0};  // every row wrong
    vecs[3] = '{1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 1'b1};  // dut_y tied 1
    vecs[4] = '{1, 16'h0000, 16'hFFFF, 16'h0000, 16, 1'b0}; // err_count at its ceiling
    vecs[5] = '{1, 16'h00FF, 16'h0F0F, 16'h00FF, 8, 1'b0};

    sel = 0; dtab_w = '0; etab_w = '0;
    reset = 1'b1; start3 = 1'b1; start4 = 1'b1;
    tick();
    sel = 0; zero_check("in_reset3");
    sel = 1; zero_check("in_reset4");
    tick();
    reset = 1'b0; start3 = 1'b0; start4 = 1'b0;
    tick();
    sel = 0; zero_check("post_reset3");
    sel = 1; zero_check("post_reset4");

    foreach (vecs[i]) begin
      sel = vecs[i].sel; dtab_w = vecs[i].dt; etab_w = vecs[i].et;
      sweep(-1, -1, tbl, errs, ps);
      check("vec_table", tbl, 32'(vecs[i].tbl));
      check("vec_errs", 32'(errs), 32'(vecs[i].errs));
      check("vec_pass", 32'(ps), 32'(vecs[i].ps));
    end

    // Start while busy is ignored; start in DONE restarts cleanly.
    sel = 0; dtab_w = 16'h00E8; etab_w = 16'h00E8;
    sweep(5, -1, tbl, errs, ps);
    sweep(-1, -1, tbl, errs, ps);
    check("restart_table", tbl, 32'h00E8);

    // Reset while stim==4 (edge E0+8 at SETTLE=1), then a full clean sweep.
    sweep(-1, 8, tbl, errs, ps);
    sweep(-1, -1, tbl, errs, ps);
    check("after_abort_table", tbl, 32'h00E8);
    check("after_abort_pass", 32'(ps), 1);

    repeat (24) begin
      int mode;
      sel    = int'($urandom_range(0, 1));
      dtab_w = 16'($urandom);
      mode   = int'($urandom_range(0, 2));
      if (mode == 0)      etab_w = dtab_w;
      else if (mode == 1) etab_w = dtab_w ^ (16'd1 << $urandom_range(0, (sel != 0) ? 15 : 7));
      else                etab_w = 16'($urandom);
      sweep(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1, -1, tbl, errs, ps);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
